// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word-aligned byte addresses to a
// one-cycle-latency program memory and presents fetched words downstream
// through a valid/ready handshake, with redirect, stall and halt support.
// Optional macro FETCH_PERF_COUNTER_EN adds perf_fetched/perf_stall counters.
module fetch_controller #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       inst_data,
  output logic              fetch_error
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] resp_pc, resp_pc_nxt;
  logic              resp_valid, resp_valid_nxt;
  logic              fetch_error_nxt;
  logic [ADDR_W-1:0] redirect_target;

  // Redirect target forced onto a word boundary; low bits only flag an error.
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Memory output is forwarded straight through; the held address keeps it stable.
  assign inst_data = imem_data;
  assign inst_pc   = resp_pc;

  // State and fetch-pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      resp_valid  <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      resp_valid  <= resp_valid_nxt;
      fetch_error <= fetch_error_nxt;
    end
  end

  // Next-state, address selection and handshake decode.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    resp_valid_nxt  = resp_valid;
    fetch_error_nxt = fetch_error;
    imem_address    = RESET_PC;
    inst_valid      = 1'b0;

    case (state)
      IDLE: begin
        if (start && !halt) begin
          state_nxt      = RUN;
          resp_valid_nxt = 1'b1;
          resp_pc_nxt    = RESET_PC;
          fetch_pc_nxt   = RESET_PC + PC_STEP;
        end
      end

      RUN: begin
        inst_valid = resp_valid && !redirect_valid && !halt;
        // Misaligned redirect is recorded even when halt wins the state decision.
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          fetch_error_nxt = 1'b1;
        end
        if (halt) begin
          state_nxt      = IDLE;
          resp_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          imem_address   = redirect_target;
          resp_pc_nxt    = redirect_target;
          resp_valid_nxt = 1'b1;
          fetch_pc_nxt   = redirect_target + PC_STEP;
        end else if (resp_valid && !inst_ready) begin
          // Re-read the presented word so memory output stays put.
          imem_address = resp_pc;
        end else begin
          imem_address   = fetch_pc;
          resp_pc_nxt    = fetch_pc;
          resp_valid_nxt = 1'b1;
          fetch_pc_nxt   = fetch_pc + PC_STEP;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_PERF_COUNTER_EN
  // Accepted-word and stalled-cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (inst_valid && inst_ready) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (inst_valid && !inst_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run against a stream-position reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  // 16-bit address instance
  logic        start, halt, redirect_valid, inst_ready;
  logic [15:0] redirect_pc, imem_address, inst_pc;
  logic [31:0] imem_data, inst_data;
  logic        inst_valid, fetch_error;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [31:0] perf_fetched8, perf_stall8;
`endif

  // 8-bit address instance for wrap-around
  logic        start8, halt8, redirect_valid8, inst_ready8;
  logic [7:0]  redirect_pc8, imem_address8, inst_pc8;
  logic [31:0] imem_data8, inst_data8;
  logic        inst_valid8, fetch_error8;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_controller #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .imem_address(imem_address), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data), .fetch_error(fetch_error)
`ifdef FETCH_PERF_COUNTER_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_controller #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .halt(halt8),
    .imem_address(imem_address8), .imem_data(imem_data8),
    .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
    .inst_valid(inst_valid8), .inst_ready(inst_ready8),
    .inst_pc(inst_pc8), .inst_data(inst_data8), .fetch_error(fetch_error8)
`ifdef FETCH_PERF_COUNTER_EN
    , .perf_fetched(perf_fetched8), .perf_stall(perf_stall8)
`endif
  );

  // Program memories: word i holds value i, one-cycle read latency.
  always @(posedge clk) imem_data  <= 32'(imem_address >> 2);
  always @(posedge clk) imem_data8 <= 32'(imem_address8 >> 2);

  // Drive the 16-bit instance for one cycle; outputs settle 1 time unit later.
  task automatic set_in(input logic s, input logic h, input logic rv,
                        input logic [15:0] rpc, input logic rdy);
    @(negedge clk);
    start = s; halt = h; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    #1;
  endtask

  // Reset, then issue a start pulse; returns inside the start cycle.
  task automatic start_stream();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_checks++; if (imem_address !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", imem_address); end
    n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", fetch_error); end
`ifdef FETCH_PERF_COUNTER_EN
    n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_stall); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    start_stream();
    n_checks++; if (imem_address !== 16'h0) begin n_fail++; $display("FAIL start_addr: got %h expected 0000", imem_address); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL start_valid: got %b expected 0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, inst_valid); end
      n_checks++; if (inst_pc !== 16'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, inst_pc, 16'(4 * i)); end
      n_checks++; if (inst_data !== 32'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, inst_data, 32'(i)); end
    end
  endtask

  task automatic test_stall();
    start_stream();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got v=%b pc=%h expected v=1 pc=0008", i, inst_valid, inst_pc); end
      n_checks++; if (inst_data !== 32'd2) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected 2", i, inst_data); end
      n_checks++; if (imem_address !== 16'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 0008", i, imem_address); end
    end
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_pc !== 16'h8 || imem_address !== 16'hC) begin n_fail++; $display("FAIL stall_release: got pc=%h addr=%h expected pc=0008 addr=000c", inst_pc, imem_address); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_pc !== 16'hC || inst_data !== 32'd3) begin n_fail++; $display("FAIL stall_next: got pc=%h data=%h expected pc=000c data=3", inst_pc, inst_data); end
`ifdef FETCH_PERF_COUNTER_EN
    n_checks++; if (perf_fetched !== 32'd3 || perf_stall !== 32'd3) begin n_fail++; $display("FAIL stall_perf: got %0d/%0d expected 3/3", perf_fetched, perf_stall); end
`endif
  endtask

  task automatic test_redirect();
    start_stream();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 16'h40, 1'b0);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash: got %b expected 0", inst_valid); end
    n_checks++; if (imem_address !== 16'h40) begin n_fail++; $display("FAIL redir_addr: got %h expected 0040", imem_address); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h40 || inst_data !== 32'h10) begin n_fail++; $display("FAIL redir_first: got v=%b pc=%h d=%h expected v=1 pc=0040 d=10", inst_valid, inst_pc, inst_data); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_pc !== 16'h44 || inst_data !== 32'h11) begin n_fail++; $display("FAIL redir_second: got pc=%h d=%h expected pc=0044 d=11", inst_pc, inst_data); end
  endtask

  task automatic test_misaligned();
    start_stream();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL mis_pre: got %b expected 0", fetch_error); end
    set_in(1'b0, 1'b0, 1'b1, 16'h42, 1'b1);
    n_checks++; if (imem_address !== 16'h40 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_addr: got addr=%h v=%b expected addr=0040 v=0", imem_address, inst_valid); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++; if (fetch_error !== 1'b1) begin n_fail++; $display("FAIL mis_sticky[%0d]: got %b expected 1", i, fetch_error); end
      n_checks++; if (inst_pc !== 16'(16'h40 + 4 * i)) begin n_fail++; $display("FAIL mis_pc[%0d]: got %h expected %h", i, inst_pc, 16'(16'h40 + 4 * i)); end
    end
  endtask

  task automatic test_wrap();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); start8 = 1'b1; inst_ready8 = 1'b1;
    @(negedge clk); start8 = 1'b0; redirect_valid8 = 1'b1; redirect_pc8 = 8'hFC; #1;
    n_checks++; if (imem_address8 !== 8'hFC) begin n_fail++; $display("FAIL wrap_addr: got %h expected fc", imem_address8); end
    @(negedge clk); redirect_valid8 = 1'b0; #1;
    n_checks++; if (inst_valid8 !== 1'b1 || inst_pc8 !== 8'hFC || inst_data8 !== 32'h3F) begin n_fail++; $display("FAIL wrap_top: got v=%b pc=%h d=%h expected v=1 pc=fc d=3f", inst_valid8, inst_pc8, inst_data8); end
    @(negedge clk); #1;
    n_checks++; if (inst_valid8 !== 1'b1 || inst_pc8 !== 8'h00 || inst_data8 !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got v=%b pc=%h d=%h expected v=1 pc=00 d=0", inst_valid8, inst_pc8, inst_data8); end
    n_checks++; if (fetch_error8 !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b expected 0", fetch_error8); end
    @(negedge clk); inst_ready8 = 1'b0;
  endtask

  task automatic test_halt_reset();
    start_stream();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0) begin n_fail++; $display("FAIL halt_pre: got v=%b pc=%h expected v=1 pc=0000", inst_valid, inst_pc); end
    set_in(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_now: got %b expected 0", inst_valid); end
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_valid !== 1'b0 || imem_address !== 16'h0) begin n_fail++; $display("FAIL halt_idle: got v=%b addr=%h expected v=0 addr=0000", inst_valid, imem_address); end
    set_in(1'b0, 1'b0, 1'b1, 16'h80, 1'b1);
    n_checks++; if (inst_valid !== 1'b0 || imem_address !== 16'h0) begin n_fail++; $display("FAIL idle_redirect: got v=%b addr=%h expected v=0 addr=0000", inst_valid, imem_address); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignored: got %b expected 0", inst_valid); end
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h4) begin n_fail++; $display("FAIL restart: got v=%b pc=%h expected v=1 pc=0004", inst_valid, inst_pc); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b0 || imem_address !== 16'h0) begin n_fail++; $display("FAIL async_reset: got v=%b addr=%h expected v=0 addr=0000", inst_valid, imem_address); end
`ifdef FETCH_PERF_COUNTER_EN
    n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin n_fail++; $display("FAIL reset_perf2: got %0d/%0d expected 0/0", perf_fetched, perf_stall); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset[%0d]: got %b expected 0", i, inst_valid); end
    end
  endtask

  // Randomized run; model tracks the stream as (base, index) from the last start/redirect.
  task automatic test_random();
    bit          running = 1'b0;
    bit          err = 1'b0;
    logic [15:0] base = 16'h0;
    int          k = 0;
    logic        s, h, rv, rdy, exp_valid;
    logic [15:0] rpc, exp_pc, exp_addr;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      s   = ($urandom_range(99) < (running ? 5 : 30));
      h   = ($urandom_range(99) < 3);
      rv  = ($urandom_range(99) < 8);
      rpc = 16'($urandom);
      if ($urandom_range(1) == 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(99) < 70);
      set_in(s, h, rv, rpc, rdy);
      exp_valid = running && !rv && !h;
      exp_pc    = base + 16'(4 * k);
      if (!running)   exp_addr = 16'h0;
      else if (rv)    exp_addr = {rpc[15:2], 2'b00};
      else if (!rdy)  exp_addr = exp_pc;
      else            exp_addr = exp_pc + 16'd4;
      n_checks++; if (inst_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, inst_valid, exp_valid); end
      n_checks++; if (fetch_error !== err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b expected %b", c, fetch_error, err); end
      if (exp_valid) begin
        n_checks++; if (inst_pc !== exp_pc || inst_data !== 32'(exp_pc >> 2)) begin n_fail++; $display("FAIL rnd_word@%0d: got pc=%h d=%h expected pc=%h d=%h", c, inst_pc, inst_data, exp_pc, 32'(exp_pc >> 2)); end
      end
      if (!(running && h)) begin
        n_checks++; if (imem_address !== exp_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, imem_address, exp_addr); end
      end
      if (running && rv && rpc[1:0] != 2'b00) err = 1'b1;
      if (!running) begin
        if (s && !h) begin running = 1'b1; base = 16'h0; k = 0; end
      end else if (h) begin
        running = 1'b0;
      end else if (rv) begin
        base = {rpc[15:2], 2'b00}; k = 0;
      end else if (rdy) begin
        k++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; inst_ready = 1'b0;
    start8 = 1'b0; halt8 = 1'b0; redirect_valid8 = 1'b0; redirect_pc8 = 8'h0; inst_ready8 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_halt_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
